csr_trap_unit: RTL and testbench

//  Parametrised machine-mode CSR file and trap sequencer. Sits beside ID/EX: serves CSR reads, applies CSRRW/RS/RC writes,

---
 rtl/csr_pkg.sv | 54 +++++
 rtl/csr_counter.sv | 28 ++
 rtl/csr_trap_unit.sv | 255 +++++++++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR file and trap sequencer.
package csr_pkg;

  // CSR addresses served by this block
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  // CSR write operation encodings
  typedef enum logic [1:0] {
    WOP_NONE  = 2'b00,
    WOP_WRITE = 2'b01,
    WOP_SET   = 2'b10,
    WOP_CLEAR = 2'b11
  } csr_wop_e;

  // mcause codes
  localparam logic [3:0] CAUSE_ECALL_M = 4'd11;
  localparam logic [3:0] CAUSE_M_TIMER = 4'd7;
  localparam logic [3:0] CAUSE_M_EXT   = 4'd11;

  // mstatus / mie / mip bit positions
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;

  // Trap sequencer states
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } trap_state_e;

  // Read-modify-write result of a CSR operation, computed at the widest XLEN
  function automatic logic [63:0] wop_apply(input logic [1:0] op,
                                            input logic [63:0] old_val,
                                            input logic [63:0] operand);
    logic [63:0] res;
    case (op)
      WOP_WRITE: res = operand;
      WOP_SET:   res = old_val | operand;
      WOP_CLEAR: res = old_val & ~operand;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running XLEN-bit counter with a CSR write port; a write beats the increment.
module csr_counter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_data,
  input  logic            inc,
  output logic [XLEN-1:0] value
);

  logic [XLEN-1:0] count;

  // Counter register: write has priority, otherwise wrap-around increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (wr_en) begin
      count <= wr_data;
    end else if (inc) begin
      count <= count + XLEN'(1);
    end
  end

  assign value = count;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file plus trap/MRET/interrupt sequencer producing a one-cycle PC redirect.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter int              HAS_COUNTERS = 1,
  parameter logic [XLEN-1:0] RESET_MTVEC  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_ren_i,
  input  logic [11:0]     csr_r_addr_i,
  output logic [XLEN-1:0] csr_r_data_o,
  output logic            csr_illegal_o,
  input  logic [1:0]      csr_wop_i,
  input  logic [11:0]     csr_w_addr_i,
  input  logic [XLEN-1:0] csr_w_data_i,
  input  logic            exc_valid_i,
  input  logic [3:0]      exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic            mret_i,
  input  logic            irq_ok_i,
  input  logic [XLEN-1:0] irq_pc_i,
  input  logic            irq_timer_i,
  input  logic            irq_ext_i,
  input  logic            retire_i,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            irq_pending_o
);

  // Architectural state
  trap_state_e       state, state_next;
  logic              status_mie, status_mpie;
  logic              mie_mtie, mie_meie;
  logic              mip_mtip, mip_meip;
  logic [XLEN-1:2]   mtvec_base;
  logic              mtvec_vec;
  logic [XLEN-1:0]   mscratch;
  logic [XLEN-1:0]   mepc;
  logic [XLEN-1:0]   mcause;
  logic [XLEN-1:0]   redirect_pc;

  // Assembled read views
  logic [XLEN-1:0]   mstatus_val, mie_val, mip_val, mtvec_val;
  logic [XLEN-1:0]   mcycle_val, minstret_val;

  // Event decode
  logic              in_idle, take_exc, take_mret, take_irq, take_any, wr_en;
  logic [3:0]        irq_code;
  logic [XLEN-1:0]   trap_pc, trap_cause, target;
  logic [63:0]       wop_res;
  logic [XLEN-1:0]   w_old, w_new;

  // True for every address this block decodes
  function automatic logic csr_implemented(input logic [11:0] addr);
    logic hit;
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
      CSR_MEPC, CSR_MCAUSE, CSR_MIP: hit = 1'b1;
      CSR_MCYCLE, CSR_MINSTRET:      hit = (HAS_COUNTERS != 0);
      default:                       hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Current value of a CSR; unimplemented addresses read as zero
  function automatic logic [XLEN-1:0] csr_value(input logic [11:0] addr);
    logic [XLEN-1:0] v;
    case (addr)
      CSR_MSTATUS:  v = mstatus_val;
      CSR_MIE:      v = mie_val;
      CSR_MTVEC:    v = mtvec_val;
      CSR_MSCRATCH: v = mscratch;
      CSR_MEPC:     v = mepc;
      CSR_MCAUSE:   v = mcause;
      CSR_MIP:      v = mip_val;
      CSR_MCYCLE:   v = mcycle_val;
      CSR_MINSTRET: v = minstret_val;
      default:      v = '0;
    endcase
    return v;
  endfunction

  // Build the read views of the bit-field CSRs (MPP is hard-wired to machine mode)
  always_comb begin
    mstatus_val               = '0;
    mstatus_val[12:11]        = 2'b11;
    mstatus_val[MSTATUS_MPIE] = status_mpie;
    mstatus_val[MSTATUS_MIE]  = status_mie;
    mie_val                   = '0;
    mie_val[MIE_MTIE]         = mie_mtie;
    mie_val[MIE_MEIE]         = mie_meie;
    mip_val                   = '0;
    mip_val[MIE_MTIE]         = mip_mtip;
    mip_val[MIE_MEIE]         = mip_meip;
    mtvec_val                 = {mtvec_base, 1'b0, mtvec_vec};
  end

  // Combinational read port and illegal-access flag
  always_comb begin
    csr_r_data_o  = '0;
    if (csr_ren_i && csr_implemented(csr_r_addr_i)) begin
      csr_r_data_o = csr_value(csr_r_addr_i);
    end
    csr_illegal_o = (csr_ren_i && !csr_implemented(csr_r_addr_i)) ||
                    ((csr_wop_i != WOP_NONE) && !csr_implemented(csr_w_addr_i));
  end

  assign irq_pending_o = status_mie & ((mie_mtie & mip_mtip) | (mie_meie & mip_meip));

  // Arbitrate this cycle's events: exception > mret > interrupt > CSR write
  always_comb begin
    in_idle   = (state == ST_IDLE);
    take_exc  = in_idle && exc_valid_i;
    take_mret = in_idle && mret_i && !exc_valid_i;
    take_irq  = in_idle && irq_pending_o && irq_ok_i && !exc_valid_i && !mret_i;
    take_any  = take_exc || take_mret || take_irq;
    wr_en     = in_idle && !take_any && (csr_wop_i != WOP_NONE) &&
                csr_implemented(csr_w_addr_i);
  end

  // Read-modify-write data for the CSR write port (old value, no bypass)
  always_comb begin
    w_old   = csr_value(csr_w_addr_i);
    wop_res = wop_apply(csr_wop_i, 64'(w_old), 64'(csr_w_data_i));
    w_new   = wop_res[XLEN-1:0];
  end

  // Trap cause, saved PC and redirect target; external beats timer
  always_comb begin
    irq_code = (mie_meie && mip_meip) ? CAUSE_M_EXT : CAUSE_M_TIMER;
    if (take_exc) begin
      trap_pc    = exc_pc_i;
      trap_cause = {{(XLEN-4){1'b0}}, exc_cause_i};
    end else begin
      trap_pc    = irq_pc_i;
      trap_cause = {1'b1, {(XLEN-5){1'b0}}, irq_code};
    end
    if (take_mret) begin
      target = mepc;
    end else if (take_irq && mtvec_vec) begin
      target = {mtvec_base, 2'b00} + {{(XLEN-6){1'b0}}, irq_code, 2'b00};
    end else begin
      target = {mtvec_base, 2'b00};
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Sequencer next state; the redirect pulse is exactly the REDIRECT state
  always_comb begin
    state_next       = state;
    redirect_valid_o = 1'b0;
    case (state)
      ST_IDLE: begin
        if (take_any) begin
          state_next = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        redirect_valid_o = 1'b1;
        state_next       = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // CSR state: trap entry, MRET and CSR writes are mutually exclusive per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_mie  <= 1'b0;
      status_mpie <= 1'b0;
      mie_mtie    <= 1'b0;
      mie_meie    <= 1'b0;
      mip_mtip    <= 1'b0;
      mip_meip    <= 1'b0;
      mtvec_base  <= RESET_MTVEC[XLEN-1:2];
      mtvec_vec   <= (RESET_MTVEC[1:0] == 2'b01);
      mscratch    <= '0;
      mepc        <= '0;
      mcause      <= '0;
      redirect_pc <= '0;
    end else begin
      mip_mtip <= irq_timer_i;
      mip_meip <= irq_ext_i;
      if (take_any) begin
        redirect_pc <= target;
      end
      if (take_exc || take_irq) begin
        mepc        <= trap_pc & ~XLEN'(3);
        mcause      <= trap_cause;
        status_mpie <= status_mie;
        status_mie  <= 1'b0;
      end else if (take_mret) begin
        status_mie  <= status_mpie;
        status_mpie <= 1'b1;
      end else if (wr_en) begin
        case (csr_w_addr_i)
          CSR_MSTATUS: begin
            status_mie  <= w_new[MSTATUS_MIE];
            status_mpie <= w_new[MSTATUS_MPIE];
          end
          CSR_MIE: begin
            mie_mtie <= w_new[MIE_MTIE];
            mie_meie <= w_new[MIE_MEIE];
          end
          CSR_MTVEC: begin
            mtvec_base <= w_new[XLEN-1:2];
            mtvec_vec  <= (w_new[1:0] == 2'b01);
          end
          CSR_MSCRATCH: mscratch <= w_new;
          CSR_MEPC:     mepc     <= w_new & ~XLEN'(3);
          CSR_MCAUSE:   mcause   <= w_new;
          default: ;
        endcase
      end
    end
  end

  assign redirect_pc_o = redirect_pc;

  // Performance counters; a same-cycle CSR write wins over the increment
  generate
    if (HAS_COUNTERS != 0) begin : g_counters
      csr_counter #(.XLEN(XLEN)) u_mcycle (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en && (csr_w_addr_i == CSR_MCYCLE)),
        .wr_data (w_new),
        .inc     (1'b1),
        .value   (mcycle_val)
      );
      csr_counter #(.XLEN(XLEN)) u_minstret (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en && (csr_w_addr_i == CSR_MINSTRET)),
        .wr_data (w_new),
        .inc     (retire_i),
        .value   (minstret_val)
      );
    end else begin : g_no_counters
      assign mcycle_val   = '0;
      assign minstret_val = '0;
    end
  endgenerate

endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench: expected redirect targets are queued when a trap/mret is driven
// and popped when the DUT raises redirect_valid_o; CSR state is checked via reads.
module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_ren_i;
  logic [11:0] csr_r_addr_i;
  logic [63:0] csr_r_data_o;
  logic        csr_illegal_o;
  logic [1:0]  csr_wop_i;
  logic [11:0] csr_w_addr_i;
  logic [63:0] csr_w_data_i;
  logic        exc_valid_i;
  logic [3:0]  exc_cause_i;
  logic [63:0] exc_pc_i;
  logic        mret_i;
  logic        irq_ok_i;
  logic [63:0] irq_pc_i;
  logic        irq_timer_i;
  logic        irq_ext_i;
  logic        retire_i;
  logic        redirect_valid_o;
  logic [63:0] redirect_pc_o;
  logic        irq_pending_o;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  csr_trap_unit #(.XLEN(64), .HAS_COUNTERS(1), .RESET_MTVEC(64'h0)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .csr_ren_i        (csr_ren_i),
    .csr_r_addr_i     (csr_r_addr_i),
    .csr_r_data_o     (csr_r_data_o),
    .csr_illegal_o    (csr_illegal_o),
    .csr_wop_i        (csr_wop_i),
    .csr_w_addr_i     (csr_w_addr_i),
    .csr_w_data_i     (csr_w_data_i),
    .exc_valid_i      (exc_valid_i),
    .exc_cause_i      (exc_cause_i),
    .exc_pc_i         (exc_pc_i),
    .mret_i           (mret_i),
    .irq_ok_i         (irq_ok_i),
    .irq_pc_i         (irq_pc_i),
    .irq_timer_i      (irq_timer_i),
    .irq_ext_i        (irq_ext_i),
    .retire_i         (retire_i),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .irq_pending_o    (irq_pending_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    csr_ren_i = 1'b0; csr_r_addr_i = '0;
    csr_wop_i = 2'b00; csr_w_addr_i = '0; csr_w_data_i = '0;
    exc_valid_i = 1'b0; exc_cause_i = '0; exc_pc_i = '0;
    mret_i = 1'b0; irq_ok_i = 1'b0; irq_pc_i = '0;
    irq_timer_i = 1'b0; irq_ext_i = 1'b0; retire_i = 1'b0;
  endtask

  task automatic csr_op(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] d);
    csr_wop_i = op; csr_w_addr_i = addr; csr_w_data_i = d;
    tick();
    csr_wop_i = 2'b00;
    $display("csr op=%0d addr=%h data=%h", op, addr, d);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [63:0] e);
    csr_ren_i = 1'b1; csr_r_addr_i = addr;
    #1;
    chk(tag, csr_r_data_o, e);
    csr_ren_i = 1'b0;
  endtask

  // Monitor: every redirect pulse must match the oldest queued target
  always @(negedge clk) begin
    if (rst_n && redirect_valid_o) begin
      $display("redirect pc=%h", redirect_pc_o);
      if (exp_q.size() == 0) begin
        chk("spurious_redirect", 64'd1, 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("redirect_pc", redirect_pc_o, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick(); tick();
    chk("rst_redirect_valid", 64'(redirect_valid_o), 64'd0);
    rst_n = 1'b1;
    rd_chk("rst_mstatus", 12'h300, 64'h1800);
    rd_chk("rst_mtvec", 12'h305, 64'h0);
    rd_chk("rst_mcycle", 12'hB00, 64'h0);
    chk("rst_redirect_pc", redirect_pc_o, 64'h0);

    // ECALL into direct mtvec
    csr_op(2'b01, 12'h305, 64'h8000_0100);
    exc_valid_i = 1'b1; exc_cause_i = 4'd11; exc_pc_i = 64'h8000_0040;
    exp_q.push_back(64'h8000_0100);
    tick();
    idle_inputs();
    rd_chk("ecall_mepc", 12'h341, 64'h8000_0040);
    rd_chk("ecall_mcause", 12'h342, 64'hB);
    rd_chk("ecall_mstatus", 12'h300, 64'h1800);
    tick();
    chk("ecall_pulse_done", 64'(redirect_valid_o), 64'd0);

    // MRET twice: MIE follows prior MPIE, MPIE set
    csr_op(2'b10, 12'h300, 64'h8);
    rd_chk("set_mie", 12'h300, 64'h1808);
    mret_i = 1'b1;
    exp_q.push_back(64'h8000_0040);
    tick();
    mret_i = 1'b0;
    rd_chk("mret1_mstatus", 12'h300, 64'h1880);
    tick();
    mret_i = 1'b1;
    exp_q.push_back(64'h8000_0040);
    tick();
    mret_i = 1'b0;
    rd_chk("mret2_mstatus", 12'h300, 64'h1888);
    tick();

    // Vectored interrupt, external beats timer
    csr_op(2'b01, 12'h305, 64'h1001);
    csr_op(2'b01, 12'h304, 64'h880);
    irq_timer_i = 1'b1; irq_ext_i = 1'b1;
    tick();
    rd_chk("mip", 12'h344, 64'h880);
    chk("irq_pending", 64'(irq_pending_o), 64'd1);
    irq_ok_i = 1'b1; irq_pc_i = 64'h2000;
    exp_q.push_back(64'h102C);
    tick();
    irq_ok_i = 1'b0; irq_timer_i = 1'b0; irq_ext_i = 1'b0;
    rd_chk("irq_mcause", 12'h342, 64'h8000_0000_0000_000B);
    rd_chk("irq_mepc", 12'h341, 64'h2000);
    rd_chk("irq_mstatus", 12'h300, 64'h1880);
    tick();

    // Set/clear ops, WARL fields, illegal address
    csr_op(2'b01, 12'h340, 64'hF0);
    csr_op(2'b10, 12'h340, 64'h0F);
    rd_chk("mscratch_set", 12'h340, 64'hFF);
    csr_op(2'b11, 12'h340, 64'hF0);
    rd_chk("mscratch_clr", 12'h340, 64'h0F);
    rd_chk("illegal_rdata", 12'h7C0, 64'h0);
    csr_ren_i = 1'b1; csr_r_addr_i = 12'h7C0; #1;
    chk("illegal_rd_flag", 64'(csr_illegal_o), 64'd1);
    csr_ren_i = 1'b0; csr_wop_i = 2'b01; csr_w_addr_i = 12'h7C0; #1;
    chk("illegal_wr_flag", 64'(csr_illegal_o), 64'd1);
    csr_wop_i = 2'b00;
    csr_op(2'b01, 12'h341, 64'h1237);
    rd_chk("mepc_align", 12'h341, 64'h1234);
    csr_op(2'b01, 12'h305, 64'h2002);
    rd_chk("mtvec_mode2", 12'h305, 64'h2000);
    csr_op(2'b01, 12'h344, 64'hFFF);
    rd_chk("mip_readonly", 12'h344, 64'h0);

    // Exception + mret + write together; REDIRECT-cycle inputs ignored
    exc_valid_i = 1'b1; exc_cause_i = 4'd2; exc_pc_i = 64'h3000; mret_i = 1'b1;
    csr_wop_i = 2'b01; csr_w_addr_i = 12'h340; csr_w_data_i = 64'hDEAD;
    exp_q.push_back(64'h2000);
    tick();
    exc_cause_i = 4'd5; exc_pc_i = 64'h4444; csr_w_data_i = 64'h55;
    tick();
    idle_inputs();
    rd_chk("prio_mscratch", 12'h340, 64'h0F);
    rd_chk("prio_mcause", 12'h342, 64'h2);
    rd_chk("prio_mepc", 12'h341, 64'h3000);
    rd_chk("prio_mstatus", 12'h300, 64'h1800);
    tick();

    // Counters: wrap and write-over-increment
    csr_op(2'b01, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    rd_chk("mcycle_ones", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    rd_chk("mcycle_wrap", 12'hB00, 64'h0);
    retire_i = 1'b1;
    tick(); tick(); tick();
    retire_i = 1'b0;
    rd_chk("minstret_cnt", 12'hB02, 64'h3);
    retire_i = 1'b1;
    csr_op(2'b01, 12'hB02, 64'h10);
    retire_i = 1'b0;
    rd_chk("minstret_wr_wins", 12'hB02, 64'h10);

    // Async reset in the middle of a redirect pulse
    exc_valid_i = 1'b1; exc_cause_i = 4'd11; exc_pc_i = 64'h5000;
    tick();
    idle_inputs();
    chk("pre_rst_valid", 64'(redirect_valid_o), 64'd1);
    chk("pre_rst_pc", redirect_pc_o, 64'h2000);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(redirect_valid_o), 64'd0);
    chk("async_rst_pc", redirect_pc_o, 64'h0);
    rd_chk("async_rst_mtvec", 12'h305, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();

    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
